// File: rtl/pipe_writer_arbiter.sv
// rtl/pipe_writer_arbiter.sv - round-robin packet arbiter framing requester streams onto the host pipe writer
module pipe_writer_arbiter #(
    parameter int NREQ    = 4,
    parameter int MAX_LEN = 256
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [8*NREQ-1:0] REQ_DATA,
    input  logic [NREQ-1:0]   REQ_LAST,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    output logic [7:0]        PUT,
    output logic              EN_PUT,
    input  logic              RDY_PUT,
    output logic              BUSY
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] END_BYTE = 8'hC0;
    localparam logic [7:0] ESC_BYTE = 8'hDB;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ESC, S_END} state_t;

    state_t        state, state_d;
    logic          ov, ov_d;
    logic [7:0]    ob, ob_d;
    logic [7:0]    esc_q, esc_d;
    logic          ending_q, ending_d;
    logic [GW-1:0] g, g_d;
    logic [GW-1:0] last_grant, last_grant_d;
    logic [15:0]   cnt, cnt_d;

    logic          can_load;
    logic          frame_end;
    logic [7:0]    cur_byte;
    logic [15:0]   cnt_inc;
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          pick_found;

    assign can_load  = !ov || RDY_PUT;
    assign cur_byte  = REQ_DATA[{g, 3'b000} +: 8];
    assign cnt_inc   = cnt + 16'd1;
    assign frame_end = REQ_LAST[g] || (cnt_inc == 16'(MAX_LEN));

    // First valid requester after the previous grant, wrapping around.
    always_comb begin
        pick       = last_grant;
        pick_found = 1'b0;
        idx        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = GW'((int'(last_grant) + k) % NREQ);
            if (!pick_found && REQ_VALID[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ov         <= 1'b0;
            ob         <= 8'h00;
            esc_q      <= 8'h00;
            ending_q   <= 1'b0;
            g          <= '0;
            last_grant <= GW'(NREQ - 1);
            cnt        <= 16'd0;
        end else begin
            ov         <= ov_d;
            ob         <= ob_d;
            esc_q      <= esc_d;
            ending_q   <= ending_d;
            g          <= g_d;
            last_grant <= last_grant_d;
            cnt        <= cnt_d;
        end
    end

    // Everything advances only when the output register can take a new byte.
    always_comb begin
        state_d      = state;
        ov_d         = ov;
        ob_d         = ob;
        esc_d        = esc_q;
        ending_d     = ending_q;
        g_d          = g;
        last_grant_d = last_grant;
        cnt_d        = cnt;
        if (can_load) begin
            ov_d = 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        ov_d         = 1'b1;
                        ob_d         = 8'(pick);
                        g_d          = pick;
                        last_grant_d = pick;
                        cnt_d        = 16'd0;
                        state_d      = S_DATA;
                    end
                end
                S_DATA: begin
                    if (REQ_VALID[g]) begin
                        ov_d     = 1'b1;
                        cnt_d    = cnt_inc;
                        ending_d = frame_end;
                        if (cur_byte == END_BYTE || cur_byte == ESC_BYTE) begin
                            ob_d    = ESC_BYTE;
                            esc_d   = (cur_byte == END_BYTE) ? 8'hDC : 8'hDD;
                            state_d = S_ESC;
                        end else begin
                            ob_d    = cur_byte;
                            state_d = frame_end ? S_END : S_DATA;
                        end
                    end
                end
                S_ESC: begin
                    ov_d    = 1'b1;
                    ob_d    = esc_q;
                    state_d = ending_q ? S_END : S_DATA;
                end
                S_END: begin
                    ov_d    = 1'b1;
                    ob_d    = END_BYTE;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        REQ_READY = '0;
        if (state == S_DATA) begin
            REQ_READY[g] = can_load;
        end
        PUT    = ob;
        EN_PUT = ov && RDY_PUT;
        BUSY   = (state != S_IDLE) || ov;
    end
endmodule

// File: tb/tb_pipe_writer_arbiter.sv
// tb/tb_pipe_writer_arbiter.sv - self-checking bench for pipe_writer_arbiter against a frame-level model
module tb_pipe_writer_arbiter;
    localparam int NREQ    = 4;
    localparam int MAX_LEN = 3;
    localparam int DEPTH   = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic [8*NREQ-1:0] REQ_DATA;
    logic [NREQ-1:0]   REQ_LAST;
    logic [NREQ-1:0]   REQ_VALID;
    logic [NREQ-1:0]   REQ_READY;
    logic [7:0]        PUT;
    logic              EN_PUT;
    logic              RDY_PUT;
    logic              BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem  [NREQ][DEPTH];
    logic       lmem [NREQ][DEPTH];
    int         len  [NREQ];
    int         pos  [NREQ];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] stall_puts[$];
    int         stall_rdy_bad;
    int         esc_rdy_bad;
    int         first_put_cyc;
    int         last_put_cyc;
    logic       finished;

    pipe_writer_arbiter #(.NREQ(NREQ), .MAX_LEN(MAX_LEN)) u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ_DATA (REQ_DATA),
        .REQ_LAST (REQ_LAST),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .PUT      (PUT),
        .EN_PUT   (EN_PUT),
        .RDY_PUT  (RDY_PUT),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset();
        RST       = 1'b1;
        REQ_VALID = '0;
        REQ_DATA  = '0;
        REQ_LAST  = '0;
        RDY_PUT   = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < NREQ; i++) len[i] = 0;
    endtask

    task automatic add_byte(input int r, input logic [7:0] b, input logic last);
        mem[r][len[r]]  = b;
        lmem[r][len[r]] = last;
        len[r]++;
    endtask

    // Frame-level model: all queued requesters stay valid, so arbitration is pure round-robin over non-empty queues.
    task automatic build_expected();
        int p[NREQ];
        int lg;
        int r;
        int c;
        logic last;
        logic [7:0] b;
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) p[i] = 0;
        lg = NREQ - 1;
        forever begin
            r = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (r < 0 && p[(lg + k) % NREQ] < len[(lg + k) % NREQ]) r = (lg + k) % NREQ;
            end
            if (r < 0) break;
            lg = r;
            exp_q.push_back(8'(r));
            c = 0;
            do begin
                b    = mem[r][p[r]];
                last = lmem[r][p[r]];
                p[r]++;
                c++;
                if (b == 8'hC0) begin
                    exp_q.push_back(8'hDB); exp_q.push_back(8'hDC);
                end else if (b == 8'hDB) begin
                    exp_q.push_back(8'hDB); exp_q.push_back(8'hDD);
                end else begin
                    exp_q.push_back(b);
                end
            end while (!(last || c == MAX_LEN));
            exp_q.push_back(8'hC0);
        end
    endtask

    // mode 0: RDY_PUT always high, 1: random, 2: low for the two cycles after the first put
    task automatic run_traffic(input int mode, input int budget);
        int   k;
        int   cyc;
        logic all_done;
        k = -1;
        cyc = 0;
        finished = 1'b0;
        got_q.delete();
        stall_puts.delete();
        stall_rdy_bad = 0;
        esc_rdy_bad   = 0;
        first_put_cyc = -1;
        last_put_cyc  = -1;
        for (int i = 0; i < NREQ; i++) pos[i] = 0;
        while (cyc < budget) begin
            @(negedge CLK);
            if (k >= 0) k++;
            for (int i = 0; i < NREQ; i++) begin
                if (pos[i] < len[i]) begin
                    REQ_VALID[i]       = 1'b1;
                    REQ_DATA[i*8 +: 8] = mem[i][pos[i]];
                    REQ_LAST[i]        = lmem[i][pos[i]];
                end else begin
                    REQ_VALID[i]       = 1'b0;
                    REQ_DATA[i*8 +: 8] = 8'h00;
                    REQ_LAST[i]        = 1'b0;
                end
            end
            case (mode)
                1:       RDY_PUT = ($urandom_range(0, 3) != 0);
                2:       RDY_PUT = !(k == 1 || k == 2);
                default: RDY_PUT = 1'b1;
            endcase
            #1;
            all_done = 1'b1;
            for (int i = 0; i < NREQ; i++) if (pos[i] < len[i]) all_done = 1'b0;
            if (all_done && got_q.size() == exp_q.size() && !BUSY) begin
                finished = 1'b1;
                break;
            end
            if (EN_PUT) begin
                got_q.push_back(PUT);
                if (first_put_cyc < 0) first_put_cyc = cyc;
                last_put_cyc = cyc;
                if (k < 0) k = 0;
            end
            if (PUT == 8'hDB && REQ_READY != '0) esc_rdy_bad++;
            if (mode == 2 && !RDY_PUT) begin
                stall_puts.push_back(PUT);
                if (REQ_READY != '0 || EN_PUT) stall_rdy_bad++;
            end
            for (int i = 0; i < NREQ; i++) if (REQ_VALID[i] && REQ_READY[i]) pos[i]++;
            cyc++;
        end
        REQ_VALID = '0;
        RDY_PUT   = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (EN_PUT !== 1'b0) begin n_fail++; $display("FAIL reset_en_put: got %0b want 0", EN_PUT); end
        n_checks++; if (PUT !== 8'h00) begin n_fail++; $display("FAIL reset_put: got %02h want 00", PUT); end
        n_checks++; if (REQ_READY !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready: got %h want 0", REQ_READY); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", BUSY); end
    endtask

    task automatic test_single_packet();
        do_reset();
        add_byte(0, 8'h11, 1'b0);
        add_byte(0, 8'h22, 1'b1);
        exp_q = '{8'h00, 8'h11, 8'h22, 8'hC0};
        run_traffic(0, 100);
        n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL single_done: got %0b want 1", finished); end
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL single_len: got %0d want 4", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL single_byte%0d: got %02h want %02h", k, got_q[k], exp_q[k]); end
        end
        n_checks++;
        if (last_put_cyc - first_put_cyc != 3) begin
            n_fail++; $display("FAIL single_consecutive: got span %0d want 3", last_put_cyc - first_put_cyc);
        end
    endtask

    task automatic test_escape();
        do_reset();
        add_byte(1, 8'hC0, 1'b0);
        add_byte(1, 8'hDB, 1'b1);
        exp_q = '{8'h01, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'hC0};
        run_traffic(0, 100);
        n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL esc_done: got %0b want 1", finished); end
        n_checks++; if (got_q.size() != 6) begin n_fail++; $display("FAIL esc_len: got %0d want 6", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL esc_byte%0d: got %02h want %02h", k, got_q[k], exp_q[k]); end
        end
        n_checks++; if (esc_rdy_bad != 0) begin n_fail++; $display("FAIL esc_ready_low: got %0d ready cycles want 0", esc_rdy_bad); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            add_byte(0, 8'h40 + 8'(n), 1'b1);
            add_byte(2, 8'h50 + 8'(n), 1'b1);
            add_byte(3, 8'h60 + 8'(n), 1'b1);
        end
        build_expected();
        run_traffic(0, 200);
        n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL rr_done: got %0b want 1", finished); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rr_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rr_byte%0d: got %02h want %02h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_max_len_split();
        do_reset();
        for (int n = 0; n < 5; n++) add_byte(0, 8'h10 + 8'(n), n == 4);
        add_byte(1, 8'h20, 1'b0);
        add_byte(1, 8'h21, 1'b1);
        exp_q = '{8'h00, 8'h10, 8'h11, 8'h12, 8'hC0, 8'h01, 8'h20, 8'h21, 8'hC0, 8'h00, 8'h13, 8'h14, 8'hC0};
        run_traffic(0, 200);
        n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL split_done: got %0b want 1", finished); end
        n_checks++; if (got_q.size() != 13) begin n_fail++; $display("FAIL split_len: got %0d want 13", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL split_byte%0d: got %02h want %02h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        add_byte(0, 8'h5A, 1'b0);
        add_byte(0, 8'h6B, 1'b0);
        add_byte(0, 8'h7C, 1'b1);
        exp_q = '{8'h00, 8'h5A, 8'h6B, 8'h7C, 8'hC0};
        run_traffic(2, 100);
        n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %0b want 1", finished); end
        n_checks++; if (got_q.size() != 5) begin n_fail++; $display("FAIL bp_len: got %0d want 5", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_byte%0d: got %02h want %02h", k, got_q[k], exp_q[k]); end
        end
        n_checks++; if (stall_puts.size() != 2) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 2", stall_puts.size()); end
        for (int k = 0; k < stall_puts.size(); k++) begin
            n_checks++;
            if (stall_puts[k] !== 8'h5A) begin n_fail++; $display("FAIL bp_stable%0d: got %02h want 5a", k, stall_puts[k]); end
        end
        n_checks++; if (stall_rdy_bad != 0) begin n_fail++; $display("FAIL bp_ready_low: got %0d bad cycles want 0", stall_rdy_bad); end
    endtask

    task automatic test_reset_mid_frame();
        int   puts;
        int   cyc;
        logic seen;
        do_reset();
        REQ_VALID = 4'b0001;
        REQ_DATA  = 32'h0000_0031;
        REQ_LAST  = 4'b0000;
        puts = 0;
        cyc  = 0;
        while (puts < 2 && cyc < 50) begin
            @(negedge CLK); #1;
            if (EN_PUT) puts++;
            cyc++;
        end
        n_checks++; if (puts != 2) begin n_fail++; $display("FAIL rst_mid_progress: got %0d puts want 2", puts); end
        RST = 1'b1;
        @(negedge CLK); #1;
        n_checks++; if (EN_PUT !== 1'b0) begin n_fail++; $display("FAIL rst_mid_en_put: got %0b want 0", EN_PUT); end
        n_checks++; if (REQ_READY !== 4'h0) begin n_fail++; $display("FAIL rst_mid_ready: got %h want 0", REQ_READY); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %0b want 0", BUSY); end
        RST       = 1'b0;
        REQ_VALID = 4'b0011;
        REQ_DATA  = 32'h0000_8877;
        REQ_LAST  = 4'b0011;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            @(negedge CLK); #1;
            if (EN_PUT) begin
                seen = 1'b1;
                n_checks++; if (PUT !== 8'h00) begin n_fail++; $display("FAIL rst_mid_header: got %02h want 00", PUT); end
            end
            cyc++;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_mid_timeout: got no header want one"); end
        REQ_VALID = '0;
    endtask

    task automatic test_random();
        int np;
        int n;
        int sel;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int r = 0; r < NREQ; r++) begin
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) begin
                    n = $urandom_range(1, 6);
                    for (int b = 0; b < n; b++) begin
                        sel = $urandom_range(0, 7);
                        add_byte(r, (sel == 0) ? 8'hC0 : (sel == 1) ? 8'hDB : 8'($urandom_range(0, 255)), b == n - 1);
                    end
                end
            end
            build_expected();
            run_traffic(1, 3000);
            n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL rand%0d_done: got %0b want 1", it, finished); end
            n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_len: got %0d want %0d", it, got_q.size(), exp_q.size()); end
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %02h want %02h", it, k, got_q[k], exp_q[k]); end
            end
            n_checks++; if (esc_rdy_bad != 0) begin n_fail++; $display("FAIL rand%0d_esc_ready: got %0d want 0", it, esc_rdy_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_escape();
        test_round_robin();
        test_max_len_split();
        test_back_pressure();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
